// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RV64I decode definitions: base opcode values (instruction[6:0]),
// the immediate-format enumeration and the default datapath width.
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int ILEN         = 32;

  // Base opcodes that carry an immediate.
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_format_e;

endpackage : rv_pkg

// File: rtl/imm_decode_comb.sv
// -----------------------------------------------------------------------------
// imm_decode_comb
// Combinational opcode-to-format decoder with per-format immediate assembly
// and sign extension to XLEN bits.
//
// Ports:
//   i_instruction  [ILEN-1:0]  instruction word
//   o_immediate    [XLEN-1:0]  sign-extended immediate (0 for unknown opcodes)
//   o_format       imm_format_e decoded immediate format
// -----------------------------------------------------------------------------
module imm_decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [ILEN-1:0] i_instruction,
  output logic [XLEN-1:0] o_immediate,
  output imm_format_e     o_format
);

  logic [31:0] w_imm32;
  logic        w_sign;

  assign w_sign = i_instruction[31];

  // Every format takes its sign from inst[31], so each immediate is first
  // built as a 32-bit sign-extended value and then widened uniformly.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    w_imm32  = '0;
    o_format = IMM_NONE;
    unique case (i_instruction[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        o_format = IMM_I;
        w_imm32  = {{20{w_sign}}, i_instruction[31:20]};
      end
      OPC_STORE: begin
        o_format = IMM_S;
        w_imm32  = {{20{w_sign}}, i_instruction[31:25], i_instruction[11:7]};
      end
      OPC_BRANCH: begin
        o_format = IMM_B;
        w_imm32  = {{19{w_sign}}, i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_format = IMM_U;
        w_imm32  = {i_instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        o_format = IMM_J;
        w_imm32  = {{11{w_sign}}, i_instruction[31], i_instruction[19:12],
                    i_instruction[20], i_instruction[30:21], 1'b0};
      end
      default: begin
        o_format = IMM_NONE;
        w_imm32  = '0;
      end
    endcase
  end

  // Widen to XLEN: fill with the sign of the 32-bit value, then drop it in.
  always_comb begin
    o_immediate        = {XLEN{w_imm32[31]}};
    o_immediate[31:0]  = w_imm32;
  end

endmodule : imm_decode_comb

// File: rtl/immediate_gen.sv
// -----------------------------------------------------------------------------
// immediate_gen
// Registered immediate extractor. The decode is combinational; this level adds
// the output register and the valid/hold behaviour (one-cycle latency).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   instr_valid  instruction word valid this cycle
//   instruction  [ILEN-1:0] instruction word
//   immediate    [XLEN-1:0] registered sign-extended immediate
//   imm_valid    registered copy of instr_valid
//   imm_format   [2:0] registered format: 0 NONE,1 I,2 S,3 B,4 U,5 J
// -----------------------------------------------------------------------------
module immediate_gen
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] immediate,
  output logic            imm_valid,
  output logic [2:0]      imm_format
);

  logic [XLEN-1:0] w_immediate;
  imm_format_e     w_format;

  logic [XLEN-1:0] r_immediate;
  logic            r_valid;
  imm_format_e     r_format;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .i_instruction (instruction),
    .o_immediate   (w_immediate),
    .o_format      (w_format)
  );

  // Reset takes priority over a simultaneous instr_valid. When idle the
  // immediate and format hold so downstream muxes see a stable value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      r_immediate <= '0;
      r_valid     <= 1'b0;
      r_format    <= IMM_NONE;
    end else begin
      r_valid <= instr_valid;
      if (instr_valid) begin
        r_immediate <= w_immediate;
        r_format    <= w_format;
      end
    end
  end

  assign immediate  = r_immediate;
  assign imm_valid  = r_valid;
  assign imm_format = r_format;

endmodule : immediate_gen

// File: tb/tb_immediate_gen.sv
// -----------------------------------------------------------------------------
// tb_immediate_gen
// Directed, table-driven bench for immediate_gen (XLEN=64).
// -----------------------------------------------------------------------------
module tb_immediate_gen;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] immediate;
  logic            imm_valid;
  logic [2:0]      imm_format;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  immediate_gen #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .immediate   (immediate),
    .imm_valid   (imm_valid),
    .imm_format  (imm_format)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] exp_imm;
    logic        exp_valid;
    logic [2:0]  exp_fmt;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [63:0] e_imm,
                               input logic e_val, input logic [2:0] e_fmt);
    check({name, ".imm"}, immediate, e_imm);
    check({name, ".valid"}, {63'b0, imm_valid}, {63'b0, e_val});
    check({name, ".fmt"}, {61'b0, imm_format}, {61'b0, e_fmt});
  endtask

  // Drive one cycle (inputs change #1 after the edge), then sample #1 after
  // the next rising edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] ins);
    rst_n       = rst;
    instr_valid = v;
    instruction = ins;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    @(posedge clk);
    #1;

    // Reset held for two edges with a valid instruction present.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h0070_0013);
      check_outputs($sformatf("reset%0d", i), 64'h0, 1'b0, 3'd0);
    end

    // name, valid, instr, exp_imm, exp_valid, exp_fmt
    vecs.push_back('{"addi7",    1, 32'h0070_0013, 64'h0000_0000_0000_0007, 1, 3'd1});
    vecs.push_back('{"ld0",      1, 32'h0000_3C03, 64'h0,                    1, 3'd1});
    vecs.push_back('{"sw0",      1, 32'h00A0_2023, 64'h0,                    1, 3'd2});
    vecs.push_back('{"beq8",     1, 32'h015C_0463, 64'h0000_0000_0000_0008, 1, 3'd3});
    vecs.push_back('{"bne_m4",   1, 32'hFE02_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 1, 3'd3});
    vecs.push_back('{"b_bit11",  1, 32'h0000_00E3, 64'h0000_0000_0000_0800, 1, 3'd3});
    vecs.push_back('{"jal0",     1, 32'h0000_006F, 64'h0,                    1, 3'd5});
    vecs.push_back('{"lui_neg",  1, 32'h8000_0037, 64'hFFFF_FFFF_8000_0000, 1, 3'd4});
    vecs.push_back('{"lui_pos",  1, 32'h1234_5037, 64'h0000_0000_1234_5000, 1, 3'd4});
    vecs.push_back('{"hold_u",   0, 32'h0070_0013, 64'h0000_0000_1234_5000, 0, 3'd4});
    vecs.push_back('{"ones",     1, 32'hFFFF_FFFF, 64'h0,                    1, 3'd0});
    vecs.push_back('{"hold0",    0, 32'h0070_0013, 64'h0,                    0, 3'd0});
    vecs.push_back('{"addi_m1",  1, 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd1});
    vecs.push_back('{"srai3",    1, 32'h4030_5093, 64'h0000_0000_0000_0403, 1, 3'd1});
    vecs.push_back('{"jalr_neg", 1, 32'h8000_0067, 64'hFFFF_FFFF_FFFF_F800, 1, 3'd1});
    vecs.push_back('{"addiw1",   1, 32'h0010_009B, 64'h0000_0000_0000_0001, 1, 3'd1});
    vecs.push_back('{"sw_m8",    1, 32'hFE00_2C23, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3'd2});
    vecs.push_back('{"sw_7ff",   1, 32'h7E00_0FA3, 64'h0000_0000_0000_07FF, 1, 3'd2});
    vecs.push_back('{"jal_big",  1, 32'h7FFF_F06F, 64'h0000_0000_000F_FFFE, 1, 3'd5});
    vecs.push_back('{"jal_b11",  1, 32'h0010_006F, 64'h0000_0000_0000_0800, 1, 3'd5});
    vecs.push_back('{"jal_b1",   1, 32'h0020_006F, 64'h0000_0000_0000_0002, 1, 3'd5});
    vecs.push_back('{"jal_neg",  1, 32'h8000_00EF, 64'hFFFF_FFFF_FFF0_0000, 1, 3'd5});
    vecs.push_back('{"auipc",    1, 32'hFFFF_F017, 64'hFFFF_FFFF_FFFF_F000, 1, 3'd4});
    vecs.push_back('{"ecall",    1, 32'h0000_0073, 64'h0,                    1, 3'd0});
    vecs.push_back('{"add_r",    1, 32'h00B5_0533, 64'h0,                    1, 3'd0});

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].valid, vecs[i].instr);
      check_outputs(vecs[i].name, vecs[i].exp_imm, vecs[i].exp_valid,
                    vecs[i].exp_fmt);
    end

    // Mid-stream reset: reset must win over the valid branch presented with it.
    step(1'b1, 1'b1, 32'h015C_0463);
    check_outputs("pre_rst", 64'h8, 1'b1, 3'd3);
    step(1'b0, 1'b1, 32'hFE02_0EE3);
    check_outputs("mid_rst", 64'h0, 1'b0, 3'd0);
    // Recovery: first instruction after reset is captured normally.
    step(1'b1, 1'b1, 32'hFE02_0EE3);
    check_outputs("post_rst", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 3'd3);
    step(1'b1, 1'b0, 32'h0000_0000);
    check_outputs("post_hold", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 3'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_immediate_gen

// File: doc/immediate_gen.md
Name: immediate_gen

Overview:
- Registered immediate extractor for the RV64I single-cycle datapath.
- Decodes the opcode of a 32-bit instruction word.
- Assembles the I/S/B/U/J immediate and sign-extends it to XLEN bits.
- Sits between instruction fetch/decode and the ALU operand mux / branch-target adder; result appears one clock after the instruction is presented.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64. Sign extension fills bits above the format's MSB.
- ILEN, 32, instruction width; fixed at 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- instr_valid  input  1  instruction word is valid this cycle.
- instruction  input  ILEN  instruction word.
- immediate  output  XLEN  sign-extended immediate (registered).
- imm_valid  output  1  immediate updated this cycle (registered copy of instr_valid).
- imm_format  output  3  decoded format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J (registered).

Behaviour:
- Reset (rst_n=0 at a clk edge): immediate=0, imm_valid=0, imm_format=NONE.
  - Reset wins over a simultaneous instr_valid.
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- instr_valid=1: immediate and imm_format load the decode result; imm_valid=1.
- instr_valid=0: imm_valid=0; immediate and imm_format hold their previous values.
- No back-pressure; a new instruction can be accepted every cycle.
- Opcode decode uses instruction[6:0]:
  - I (0000011 load, 0010011 OP-IMM, 0011011 OP-IMM-32, 1100111 JALR): imm = sext(inst[31:20]).
    - Shift encodings are not special-cased. The full 12-bit field is sign-extended, so srai yields 0x400|shamt.
  - S (0100011): imm = sext({inst[31:25], inst[11:7]}).
  - B (1100011): imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); bit 0 is always 0.
  - U (0110111 LUI, 0010111 AUIPC): imm = sext({inst[31:12], 12'b0}); for XLEN=64, bits 63:32 replicate inst[31].
  - J (1101111): imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode (incl. SYSTEM, R-type, all-ones): imm = 0, format = NONE.
- Sign source is always inst[31].
- Only bits [6:0] participate in format selection; funct3/funct7 are ignored.
- Decode is purely combinational ahead of the output register; there is no other state.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams: OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
  - the imm_format enum (IMM_NONE..IMM_J).
  - XLEN default.
- One sub-module, imm_decode_comb: a combinational opcode-to-format decoder plus per-format assembly and sign extension.
- The top level adds only the output register stage and the valid/hold logic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with instr_valid=1, instruction=0x00700013 -> immediate=0, imm_valid=0, imm_format=0.
- I/L/S: one per cycle, one cycle after each:
  - 0x00700013 -> 0x0000000000000007, fmt I.
  - 0x00003C03 -> 0x0, fmt I.
  - 0x00A02023 -> 0x0, fmt S.
- B-type back-to-back:
  - 0x015C0463 -> 0x0000000000000008.
  - Next cycle 0xFE020EE3 -> 0xFFFFFFFFFFFFFFFC; fmt B both.
- J/U:
  - 0x0000006F -> 0x0, fmt J.
  - 0x80000037 -> 0xFFFFFFFF80000000, fmt U.
  - 0x12345037 -> 0x0000000012345000.
- Unknown and hold:
  - 0xFFFFFFFF -> immediate 0, fmt NONE.
  - Then instr_valid=0 with instruction=0x00700013 -> imm_valid=0, immediate stays 0.
- Mid-stream reset: rst_n=0 on the edge where 0xFE020EE3 is presented -> outputs 0 next cycle, not 0xFFFFFFFFFFFFFFFC.
